serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Receiving end of the team's single-wire serial link: recovers framed words from the serial line that the transmitter drives bit by bit through flip-flop stages. It synchronises the asynchronous line, detects a start bit, and samples each bit at mid-cell. It shifts data in LSB-first, checks the stop bit, and presents each word on a parallel output with a one-cycle valid strobe. It sits at the boundary between the serial link and the parallel datapath.

## Interface
- DATA_W, 8, data bits per frame (1..16)
- CLKS_PER_BIT, 4, clock cycles per bit cell (even, >= 2)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset; one clock, reset asynchronous active-low
- d  input  1  serial line, idle high, asynchronous to clk
- data  output  DATA_W  last correctly framed word; holds until next good frame
- valid  output  1  one-cycle pulse, data updated this cycle
- frame_err  output  1  one-cycle pulse, stop bit sampled low
- busy  output  1  high in every state except IDLE

## Operation
- Frame format: start bit (0), DATA_W data bits LSB first, one stop bit (1); each bit lasts CLKS_PER_BIT cycles.
- d passes through a 2-flop synchroniser. The FSM sees only d_s, which is d delayed 2 cycles; d_s resets to 1.
- Cycle counter cnt has width $clog2(CLKS_PER_BIT). Bit index bidx has width $clog2(DATA_W+1). Shift register sh is DATA_W wide.
- IDLE: cnt=0, bidx=0. On d_s==0 -> START.
- START: cnt counts up. At cnt==CLKS_PER_BIT/2-1:
  - d_s==0: -> DATA, cnt=0.
  - d_s==1: glitch; -> IDLE with no pulse and no error.
- DATA: cnt counts 0..CLKS_PER_BIT-1 and wraps. At cnt==CLKS_PER_BIT-1: sh <= {d_s, sh[DATA_W-1:1]}, bidx++. After the DATA_W-th sample -> STOP, cnt=0.
- STOP: at cnt==CLKS_PER_BIT-1 sample d_s:
  - 1: data<=sh, valid=1, -> IDLE.
  - 0: frame_err=1, data unchanged, -> WAIT_HIGH.
- WAIT_HIGH: stay until d_s==1, then -> IDLE. This prevents a held-low line (break) from retriggering frames.
- A start edge may arrive in the first IDLE cycle after a stop sample. Back-to-back frames with no idle gap are supported.
- valid and frame_err are never high together, and never high for two consecutive cycles.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE
  - data=0, valid=0, frame_err=0, busy=0
  - sh=0, cnt=0, bidx=0
  - both synchroniser flops=1
- Reset mid-frame aborts the frame with no pulse. The first frame after rst deasserts is received normally.
- t0 is the first cycle in IDLE with d_s==0. Sample points:
  - Start check: t0+CLKS_PER_BIT/2.
  - Data bit i (0-based): t0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT.
  - Stop bit: t0+CLKS_PER_BIT/2+(DATA_W+1)*CLKS_PER_BIT.
- valid/frame_err are registered and assert in the cycle after the stop sample.
- End-to-end latency from the start-bit falling edge on d to valid: 2 + CLKS_PER_BIT/2 + (DATA_W+1)*CLKS_PER_BIT + 1 cycles. With the defaults this is 41.
- busy rises the cycle after t0 and falls the cycle valid asserts. It stays high through WAIT_HIGH.

## Structure
- Package serial_link_pkg holds:
  - The state enum {IDLE, START, DATA, STOP, WAIT_HIGH}.
  - Localparams for the idle line level (1), start level (0) and stop level (1), shared with the transmitter.
- Sub-module sync_2ff: a 2-stage synchroniser with an asynchronous active-low reset value parameter (RST_VAL=1). It is built from the team's D flip-flop.
- Everything else (FSM, counters, shift register, output registers) lives in serial_frame_rx.

## Test plan
All scenarios use DATA_W=8, CLKS_PER_BIT=4.
- Frame 0xA5 with a good stop bit -> data=0xA5, valid high exactly 1 cycle, 41 cycles after the start edge; frame_err stays 0.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two valid pulses 40 cycles apart; data=0x00, then 0xFF.
- d low for 1 cycle only (glitch) -> no valid, no frame_err; busy returns to 0 within 5 cycles.
- Frame 0x3C with stop bit 0, line then held low 20 cycles -> one frame_err pulse, data keeps the previous value, no new frame until d returns high.
- rst pulsed low mid-frame after 4 data bits -> all outputs 0 immediately; a following frame 0x5A is received correctly.
- Random 200 frames with random idle gaps (0-10 cycles) -> every word matches in order; no spurious valid or frame_err.

Source files
------------

// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared state encoding and line levels for the serial link
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // Line levels agreed with the transmitter
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-stage synchroniser for an asynchronous single-bit input
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next-state of the two stages: a plain shift toward the output
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Both stages reset to the idle line level so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver: start detect, mid-cell sampling, stop check
module serial_frame_rx
    import serial_link_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 0) ? $clog2(DATA_W + 1) : 1;

    // Half-cell point for the start check, last cycle of a cell for data/stop samples
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIDX_LAST = BW'(DATA_W - 1);

    logic              d_s;
    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bidx_q, bidx_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    sync_2ff #(
        .RST_VAL (LINE_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (d),
        .q     (d_s)
    );

    // Frame FSM next-state: counters, LSB-first shift, stop check and output strobes
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bidx_d      = bidx_q;
        sh_d        = sh_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bidx_d = '0;
                if (d_s == LINE_START) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    // A line that is high again at mid-cell was a glitch, not a start bit
                    state_d = (d_s == LINE_START) ? DATA : IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    // Width-safe form of {d_s, sh_q[DATA_W-1:1]}, also valid for DATA_W == 1
                    sh_d   = DATA_W'({d_s, sh_q} >> 1);
                    bidx_d = bidx_q + BW'(1);
                    if (bidx_q == BIDX_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (d_s == LINE_STOP) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line is released so a break cannot start frames
                if (d_s == LINE_IDLE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Frame FSM state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bidx_q      <= '0;
            sh_q        <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bidx_q      <= bidx_d;
            sh_q        <= sh_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - scoreboard bench for serial_frame_rx
module tb_serial_frame_rx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int LAT = 41;

    logic          clk;
    logic          rst_n;
    logic          d;
    logic [DW-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          busy;

    int unsigned cyc;
    int          n_checks;
    int          n_fails;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        int unsigned cyc;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] last_good;
    bit         prev_pulse;
    ev_t        mon_e;

    serial_frame_rx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .d         (d),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_bit(input logic b);
        d = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        d = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; pushes the expected pulse, then drives the frame
    task automatic send_frame(input logic [7:0] w, input bit good);
        ev_t e;
        e.is_err = !good;
        e.data   = good ? w : last_good;
        e.cyc    = cyc + LAT;
        exp_q.push_back(e);
        if (good) last_good = w;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(w[i]);
        drive_bit(good);
    endtask

    // Monitor: every output pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pulse = 1'b0;
        end else begin
            if (valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pulse", {30'd0, valid, frame_err}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_kind_ferr", {31'd0, frame_err}, {31'd0, mon_e.is_err});
                    chk("pulse_data", {24'd0, data}, {24'd0, mon_e.data});
                    chk("pulse_cycle", cyc, mon_e.cyc);
                end
                chk("valid_and_ferr", {31'd0, valid && frame_err}, 32'd0);
                chk("pulse_two_cycles", {31'd0, prev_pulse}, 32'd0);
            end
            prev_pulse = valid || frame_err;
        end
    end

    initial begin
        int unsigned s;
        n_checks  = 0;
        n_fails   = 0;
        last_good = 8'h00;
        rst_n     = 1'b0;
        d         = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle(4);

        // Single good frame
        send_frame(8'hA5, 1'b1);
        idle(6);

        // Back-to-back, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(6);

        // One-cycle glitch on the line
        s = cyc;
        d = 1'b0;
        @(negedge clk);
        d = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_up", {31'd0, busy}, 32'd1);
        chk("glitch_busy_cyc", cyc, s + 3);
        repeat (2) @(negedge clk);
        chk("glitch_busy_down", {31'd0, busy}, 32'd0);
        idle(4);

        // Bad stop bit followed by a held-low line
        send_frame(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        chk("break_busy", {31'd0, busy}, 32'd1);
        chk("break_data_kept", {24'd0, data}, {24'd0, last_good});
        idle(6);
        chk("break_release_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a frame, after four data bits
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rst_n = 1'b0;
        d     = 1'b1;
        #1;
        chk("midrst_data", {24'd0, data}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        last_good = 8'h00;
        idle(2);
        send_frame(8'h5A, 1'b1);
        idle(4);

        // Random frames with random gaps
        for (int k = 0; k < 200; k++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1);
            idle($urandom_range(0, 10));
        end

        idle(60);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
